// File: rtl/mux_pkg.sv
// Shared definitions for the 4:1 byte multiplexer and the 1:4 stream demultiplexer.
package mux_pkg;

  localparam int unsigned SEL_W  = 2;
  localparam int unsigned NUM_CH = 4;

  typedef logic [SEL_W-1:0] sel_t;

  localparam sel_t SEL_A = 2'b00;
  localparam sel_t SEL_B = 2'b01;
  localparam sel_t SEL_C = 2'b10;
  localparam sel_t SEL_D = 2'b11;

  // Modulo-NUM_CH successor of a channel selector; wraps naturally at SEL_W bits.
  function automatic sel_t sel_next(sel_t s);
    return s + sel_t'(1);
  endfunction

endpackage

// File: rtl/demux_slot.sv
// One-entry registered output slot with valid/ready handshake.
// A load on the same edge as a drain wins, so the slot stays full with the new word.
module demux_slot #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             ready,
  output logic [WIDTH-1:0] data,
  output logic             valid
);

  // Slot register: load has priority over drain; data holds until the next load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= load_data;
    end else if (valid && ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/stream_demux4.sv
// 1-to-4 stream demultiplexer: routes each accepted word into one of four registered slots,
// selected by InSel or by an internal round-robin pointer.
module stream_demux4
  import mux_pkg::*;
#(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned RR_MODE = 0
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic [WIDTH-1:0] InVal,
  input  logic [1:0]       InSel,
  input  logic             InValid,
  output logic             InReady,
  output logic [WIDTH-1:0] OutA,
  output logic [WIDTH-1:0] OutB,
  output logic [WIDTH-1:0] OutC,
  output logic [WIDTH-1:0] OutD,
  output logic             OutValidA,
  output logic             OutValidB,
  output logic             OutValidC,
  output logic             OutValidD,
  input  logic             OutReadyA,
  input  logic             OutReadyB,
  input  logic             OutReadyC,
  input  logic             OutReadyD,
  output logic [1:0]       RrPtr
);

  sel_t              rr_ptr;
  sel_t              dest;
  logic              accept;
  logic [NUM_CH-1:0] slot_valid;
  logic [NUM_CH-1:0] slot_ready;
  logic [NUM_CH-1:0] load_vec;
  logic [WIDTH-1:0]  slot_data [NUM_CH];

  assign slot_ready = {OutReadyD, OutReadyC, OutReadyB, OutReadyA};

  // Destination and input handshake; InReady depends only on dest and the slot state.
  always_comb begin
    dest    = (RR_MODE != 0) ? rr_ptr : sel_t'(InSel);
    InReady = !slot_valid[dest] || slot_ready[dest];
    accept  = InValid && InReady;
  end

  // One-hot load strobe for the destination slot.
  always_comb begin
    load_vec = '0;
    if (accept) begin
      unique case (dest)
        SEL_A: load_vec = 4'b0001;
        SEL_B: load_vec = 4'b0010;
        SEL_C: load_vec = 4'b0100;
        SEL_D: load_vec = 4'b1000;
        default: load_vec = '0;
      endcase
    end
  end

  // Round-robin pointer advances on every accept, in both modes.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      rr_ptr <= SEL_A;
    end else if (accept) begin
      rr_ptr <= sel_next(rr_ptr);
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_slot
    demux_slot #(
      .WIDTH(WIDTH)
    ) u_slot (
      .clk      (Clk),
      .rst      (Rst),
      .load     (load_vec[g]),
      .load_data(InVal),
      .ready    (slot_ready[g]),
      .data     (slot_data[g]),
      .valid    (slot_valid[g])
    );
  end

  assign OutA      = slot_data[0];
  assign OutB      = slot_data[1];
  assign OutC      = slot_data[2];
  assign OutD      = slot_data[3];
  assign OutValidA = slot_valid[0];
  assign OutValidB = slot_valid[1];
  assign OutValidC = slot_valid[2];
  assign OutValidD = slot_valid[3];
  assign RrPtr     = rr_ptr;

endmodule

// File: tb/tb_stream_demux4.sv
// Bench for stream_demux4: instance 0 routes by InSel, instance 1 by round-robin.
module tb_stream_demux4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] in_val   [2];
  logic [1:0] in_sel   [2];
  logic       in_valid [2];
  logic [3:0] out_rdy  [2];
  logic       in_rdy   [2];
  logic [7:0] od0 [4];
  logic [7:0] od1 [4];
  logic [3:0] ov0, ov1;
  logic [1:0] ptr [2];

  int checks   = 0;
  int failures = 0;

  stream_demux4 #(.WIDTH(8), .RR_MODE(0)) u_dut0 (
    .Clk(clk), .Rst(rst), .InVal(in_val[0]), .InSel(in_sel[0]), .InValid(in_valid[0]),
    .InReady(in_rdy[0]),
    .OutA(od0[0]), .OutB(od0[1]), .OutC(od0[2]), .OutD(od0[3]),
    .OutValidA(ov0[0]), .OutValidB(ov0[1]), .OutValidC(ov0[2]), .OutValidD(ov0[3]),
    .OutReadyA(out_rdy[0][0]), .OutReadyB(out_rdy[0][1]), .OutReadyC(out_rdy[0][2]),
    .OutReadyD(out_rdy[0][3]), .RrPtr(ptr[0])
  );

  stream_demux4 #(.WIDTH(8), .RR_MODE(1)) u_dut1 (
    .Clk(clk), .Rst(rst), .InVal(in_val[1]), .InSel(in_sel[1]), .InValid(in_valid[1]),
    .InReady(in_rdy[1]),
    .OutA(od1[0]), .OutB(od1[1]), .OutC(od1[2]), .OutD(od1[3]),
    .OutValidA(ov1[0]), .OutValidB(ov1[1]), .OutValidC(ov1[2]), .OutValidD(ov1[3]),
    .OutReadyA(out_rdy[1][0]), .OutReadyB(out_rdy[1][1]), .OutReadyC(out_rdy[1][2]),
    .OutReadyD(out_rdy[1][3]), .RrPtr(ptr[1])
  );

  function automatic logic [7:0] get_od(int i, int ch);
    return (i == 0) ? od0[ch] : od1[ch];
  endfunction

  function automatic logic [3:0] get_ov(int i);
    return (i == 0) ? ov0 : ov1;
  endfunction

  // Reference model: per-instance arrays of slot contents and a modulo-4 pointer.
  logic       mv [2][4];
  logic [7:0] md [2][4];
  int         mp [2];
  logic       stalled [2];

  function automatic int mdest(int i);
    return (i == 1) ? mp[i] : int'(in_sel[i]);
  endfunction

  function automatic logic mready(int i);
    return !mv[i][mdest(i)] || out_rdy[i][mdest(i)];
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        for (int ch = 0; ch < 4; ch++) begin
          mv[i][ch] <= 1'b0;
          md[i][ch] <= 8'h00;
        end
        mp[i]      <= 0;
        stalled[i] <= 1'b0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        for (int ch = 0; ch < 4; ch++) begin
          if (in_valid[i] && mready(i) && mdest(i) == ch) begin
            mv[i][ch] <= 1'b1;
            md[i][ch] <= in_val[i];
          end else if (out_rdy[i][ch]) begin
            mv[i][ch] <= 1'b0;
          end
        end
        if (in_valid[i] && mready(i)) mp[i] <= (mp[i] + 1) % 4;
        stalled[i] <= in_valid[i] && !mready(i);
      end
    end
  end

  task automatic chk(string name, int i, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s inst%0d: got %0h want %0h at %0t", name, i, act, exp, $time);
    end
  endtask

  task automatic compare_model(int i);
    chk("rnd_in_ready", i, 32'(in_rdy[i]), 32'(mready(i)));
    for (int ch = 0; ch < 4; ch++) begin
      chk("rnd_valid", i, 32'(get_ov(i)[ch]), 32'(mv[i][ch]));
      chk("rnd_data", i, 32'(get_od(i, ch)), 32'(md[i][ch]));
    end
    chk("rnd_ptr", i, 32'(ptr[i]), 32'(mp[i]));
  endtask

  typedef struct {
    int         inst;
    logic [1:0] sel;
    logic [7:0] val;
    logic [3:0] exp_valid;
    logic [1:0] exp_ptr;
    int         exp_ch;
  } vec_t;

  vec_t vt [9];

  initial begin
    for (int i = 0; i < 2; i++) begin
      in_val[i] = 8'h00; in_sel[i] = 2'b00; in_valid[i] = 1'b0; out_rdy[i] = 4'hf;
    end

    // Reset state
    #1 rst = 1'b1;
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("rst_valid", i, 32'(get_ov(i)), 32'h0);
      for (int ch = 0; ch < 4; ch++) chk("rst_data", i, 32'(get_od(i, ch)), 32'h0);
      chk("rst_ptr", i, 32'(ptr[i]), 32'h0);
      chk("rst_in_ready", i, 32'(in_rdy[i]), 32'h1);
    end
    @(negedge clk) rst = 1'b0;

    // Directed table: sel-routed sequence then round-robin with InSel tied to 3
    vt[0] = '{0, 2'd0, 8'h0a, 4'b0001, 2'd1, 0};
    vt[1] = '{0, 2'd1, 8'h0b, 4'b0010, 2'd2, 1};
    vt[2] = '{0, 2'd2, 8'h0c, 4'b0100, 2'd3, 2};
    vt[3] = '{0, 2'd3, 8'h0d, 4'b1000, 2'd0, 3};
    vt[4] = '{1, 2'd3, 8'h01, 4'b0001, 2'd1, 0};
    vt[5] = '{1, 2'd3, 8'h02, 4'b0010, 2'd2, 1};
    vt[6] = '{1, 2'd3, 8'h03, 4'b0100, 2'd3, 2};
    vt[7] = '{1, 2'd3, 8'h04, 4'b1000, 2'd0, 3};
    vt[8] = '{1, 2'd3, 8'h05, 4'b0001, 2'd1, 0};
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      in_valid[0] = 1'b0; in_valid[1] = 1'b0;
      in_valid[vt[k].inst] = 1'b1;
      in_sel[vt[k].inst]   = vt[k].sel;
      in_val[vt[k].inst]   = vt[k].val;
      #1 chk("tbl_in_ready", vt[k].inst, 32'(in_rdy[vt[k].inst]), 32'h1);
      @(posedge clk); #1;
      chk("tbl_valid", vt[k].inst, 32'(get_ov(vt[k].inst)), 32'(vt[k].exp_valid));
      chk("tbl_ptr", vt[k].inst, 32'(ptr[vt[k].inst]), 32'(vt[k].exp_ptr));
      chk("tbl_data", vt[k].inst, 32'(get_od(vt[k].inst, vt[k].exp_ch)), 32'(vt[k].val));
    end

    // Back-pressure on B: second word waits, then replaces the first with no bubble
    @(negedge clk);
    in_valid[1] = 1'b0;
    out_rdy[0] = 4'b1101; in_valid[0] = 1'b1; in_sel[0] = 2'd1; in_val[0] = 8'h11;
    #1 chk("bp_first_ready", 0, 32'(in_rdy[0]), 32'h1);
    @(posedge clk); #1;
    chk("bp_first_data", 0, 32'(od0[1]), 32'h11);
    @(negedge clk);
    in_val[0] = 8'h22;
    #1 chk("bp_stall_ready", 0, 32'(in_rdy[0]), 32'h0);
    repeat (2) begin
      @(posedge clk); #1;
      chk("bp_hold_data", 0, 32'(od0[1]), 32'h11);
      chk("bp_hold_valid", 0, 32'(ov0[1]), 32'h1);
      chk("bp_hold_ptr", 0, 32'(ptr[0]), 32'h1);
    end
    @(negedge clk);
    out_rdy[0] = 4'hf;
    #1 chk("bp_release_ready", 0, 32'(in_rdy[0]), 32'h1);
    @(posedge clk); #1;
    chk("bp_new_data", 0, 32'(od0[1]), 32'h22);
    chk("bp_new_valid", 0, 32'(ov0[1]), 32'h1);
    chk("bp_new_ptr", 0, 32'(ptr[0]), 32'h2);
    @(negedge clk) in_valid[0] = 1'b0;

    // Full: fill A..D with no consumer ready, then everything stalls
    @(negedge clk);
    out_rdy[0] = 4'h0;
    for (int s = 0; s < 4; s++) begin
      in_valid[0] = 1'b1; in_sel[0] = 2'(s); in_val[0] = 8'(8'h31 + s);
      #1 chk("full_fill_ready", 0, 32'(in_rdy[0]), 32'h1);
      @(negedge clk);
    end
    in_sel[0] = 2'd0; in_val[0] = 8'h35;
    #1 chk("full_stall_ready", 0, 32'(in_rdy[0]), 32'h0);
    repeat (2) @(posedge clk);
    #1;
    chk("full_valid", 0, 32'(ov0), 32'hf);
    chk("full_data_a", 0, 32'(od0[0]), 32'h31);
    chk("full_data_d", 0, 32'(od0[3]), 32'h34);
    chk("full_ptr", 0, 32'(ptr[0]), 32'h2);
    @(negedge clk);
    in_valid[0] = 1'b0;
    for (int s = 0; s < 4; s++) begin
      in_sel[0] = 2'(s);
      #1 chk("full_any_dest", 0, 32'(in_rdy[0]), 32'h0);
    end
    out_rdy[0] = 4'hf;

    // Async reset with held words in the round-robin instance
    out_rdy[1] = 4'h0;
    for (int s = 0; s < 4; s++) begin
      in_valid[1] = 1'b1; in_val[1] = 8'(8'h41 + s);
      @(negedge clk);
    end
    in_valid[1] = 1'b0;
    #1 chk("pre_rst_valid", 1, 32'(ov1), 32'hf);
    #1 rst = 1'b1;
    #1;
    chk("async_rst_valid", 1, 32'(ov1), 32'h0);
    chk("async_rst_ptr", 1, 32'(ptr[1]), 32'h0);
    chk("async_rst_data", 1, 32'(od1[2]), 32'h0);
    chk("async_rst_valid", 0, 32'(ov0), 32'h0);
    @(negedge clk) rst = 1'b0;
    @(negedge clk);
    out_rdy[1] = 4'hf; in_valid[1] = 1'b1; in_val[1] = 8'h77;
    @(posedge clk); #1;
    chk("post_rst_valid", 1, 32'(ov1), 32'h1);
    chk("post_rst_data", 1, 32'(od1[0]), 32'h77);
    chk("post_rst_ptr", 1, 32'(ptr[1]), 32'h1);
    @(negedge clk) in_valid[1] = 1'b0;

    // Randomized traffic against the model; stalled words are held stable
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        if (!stalled[i]) begin
          in_valid[i] = ($urandom_range(0, 3) != 0);
          in_sel[i]   = 2'($urandom);
          in_val[i]   = 8'($urandom);
        end
        out_rdy[i] = 4'($urandom);
      end
      #1;
      compare_model(0);
      compare_model(1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
